game_countdown_timer: RTL and testbench

//   Parametrised countdown timer for game rounds: internal 1 s prescaler, N-digit

---
 rtl/game_countdown_timer.sv | 151 +++++++++++++++
 tb/tb_game_countdown_timer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/game_countdown_timer.sv
// Round countdown timer: 1 s prescaler, pause/resume, reload, saturating bonus,
// low-time warning and registered N-digit ASCII readout for the text path.
module game_countdown_timer #(
    parameter int TICK_DIV   = 100_000_000,
    parameter int NUM_DIGITS = 2,
    parameter int START_SECS = 31,
    parameter int BONUS_SECS = 5,
    parameter int WARN_SECS  = 5,
    localparam int MAX_SECS  = 10**NUM_DIGITS - 1,
    localparam int CNT_W     = $clog2(MAX_SECS + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    pause,
    input  logic                    load,
    input  logic                    bonus,
    output logic [CNT_W-1:0]        secs_left,
    output logic [7*NUM_DIGITS-1:0] time_ascii,
    output logic                    running,
    output logic                    paused,
    output logic                    timer_done,
    output logic                    done_pulse,
    output logic                    warn
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RUNNING = 2'd1;
    localparam logic [1:0] PAUSED  = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    localparam logic [CNT_W-1:0] MAX_V   = CNT_W'(MAX_SECS);
    localparam logic [CNT_W-1:0] START_V = CNT_W'(START_SECS);
    localparam logic [CNT_W-1:0] BONUS_V = CNT_W'((BONUS_SECS > MAX_SECS) ? MAX_SECS : BONUS_SECS);
    localparam logic [CNT_W-1:0] WARN_V  = CNT_W'((WARN_SECS > MAX_SECS) ? MAX_SECS : WARN_SECS);
    localparam logic [CNT_W-1:0] TEN     = CNT_W'(10);
    localparam logic [CNT_W:0]   SUM_ONE = (CNT_W+1)'(1);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    // Binary to leading-zero ASCII decimal, units digit in the low 7 bits.
    function automatic logic [7*NUM_DIGITS-1:0] to_ascii(input logic [CNT_W-1:0] value);
        logic [7*NUM_DIGITS-1:0] result;
        logic [CNT_W-1:0]        rest;
        logic [CNT_W-1:0]        digit;
        result = '0;
        rest   = value;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit              = rest % TEN;
            result[7*i +: 7]   = 7'h30 + 7'(digit);
            rest               = rest / TEN;
        end
        return result;
    endfunction

    localparam logic [7*NUM_DIGITS-1:0] START_ASCII = to_ascii(START_V);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [PRE_W-1:0] presc;
    logic [PRE_W-1:0] presc_nxt;
    logic [CNT_W-1:0] secs_nxt;
    logic [CNT_W:0]   sum;
    logic             tick;
    logic             enter_done;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no latch is inferred.
        state_nxt  = state;
        presc_nxt  = presc;
        secs_nxt   = secs_left;
        enter_done = 1'b0;
        tick       = 1'b0;
        sum        = '0;

        if (load) begin
            state_nxt = IDLE;
            presc_nxt = '0;
            secs_nxt  = START_V;
        end else begin
            case (state)
                IDLE: begin
                    presc_nxt = '0;
                    if (start) begin
                        if (START_V == '0) begin
                            state_nxt  = DONE;
                            enter_done = 1'b1;
                        end else if (pause) begin
                            state_nxt = PAUSED;
                        end else begin
                            state_nxt = RUNNING;
                        end
                    end
                end
                RUNNING: begin
                    // Pausing freezes the prescaler so the partial second is kept.
                    if (pause) begin
                        state_nxt = PAUSED;
                    end else begin
                        tick      = (presc == PRE_LAST);
                        presc_nxt = tick ? '0 : presc + PRE_ONE;
                    end
                end
                PAUSED: begin
                    if (!pause) state_nxt = RUNNING;
                end
                default: begin
                end
            endcase

            if (state == RUNNING || state == PAUSED) begin
                sum = {1'b0, secs_left} + (bonus ? {1'b0, BONUS_V} : '0);
                if (tick && sum != '0) sum = sum - SUM_ONE;
                secs_nxt = (sum > {1'b0, MAX_V}) ? MAX_V : sum[CNT_W-1:0];
                if (tick && secs_nxt == '0) begin
                    state_nxt  = DONE;
                    enter_done = 1'b1;
                end
            end
        end
    end

    // NOTE: every register here has a defined async reset value; nothing is left to power-up state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            presc      <= '0;
            secs_left  <= START_V;
            time_ascii <= START_ASCII;
            running    <= 1'b0;
            paused     <= 1'b0;
            timer_done <= 1'b0;
            done_pulse <= 1'b0;
            warn       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state      <= state_nxt;
            presc      <= presc_nxt;
            secs_left  <= secs_nxt;
            time_ascii <= to_ascii(secs_nxt);
            running    <= (state_nxt == RUNNING);
            paused     <= (state_nxt == PAUSED);
            timer_done <= (state_nxt == DONE);
            done_pulse <= enter_done;
            warn       <= ((state_nxt == RUNNING) || (state_nxt == PAUSED)) && (secs_nxt <= WARN_V);
        end
    end

endmodule

// File: tb/tb_game_countdown_timer.sv
// Bench for game_countdown_timer: directed steps plus random stimulus against a
// cycle-level arithmetic model; extra builds cover saturation and zero start.
module tb_game_countdown_timer;

    localparam int T    = 4;
    localparam int S    = 3;
    localparam int B    = 5;
    localparam int W    = 2;
    localparam int MAXS = 99;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b1;
    logic start = 1'b0, pause = 1'b0, load = 1'b0, bonus = 1'b0;
    logic [6:0]  secs_left;
    logic [13:0] time_ascii;
    logic running, paused, timer_done, done_pulse, warn;

    logic a_start = 1'b0, a_bonus = 1'b0;
    logic [6:0]  a_secs;
    logic [13:0] a_ascii;
    logic a_running, a_paused, a_done, a_pulse, a_warn;

    logic z_start = 1'b0;
    logic [6:0]  z_secs;
    logic [13:0] z_ascii;
    logic z_running, z_paused, z_done, z_pulse, z_warn;

    game_countdown_timer #(.TICK_DIV(T), .NUM_DIGITS(2), .START_SECS(S), .BONUS_SECS(B), .WARN_SECS(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .load(load), .bonus(bonus),
        .secs_left(secs_left), .time_ascii(time_ascii), .running(running), .paused(paused),
        .timer_done(timer_done), .done_pulse(done_pulse), .warn(warn));

    game_countdown_timer #(.TICK_DIV(T), .NUM_DIGITS(2), .START_SECS(97), .BONUS_SECS(B), .WARN_SECS(W)) dut97 (
        .clk(clk), .rst_n(rst_n), .start(a_start), .pause(1'b0), .load(1'b0), .bonus(a_bonus),
        .secs_left(a_secs), .time_ascii(a_ascii), .running(a_running), .paused(a_paused),
        .timer_done(a_done), .done_pulse(a_pulse), .warn(a_warn));

    game_countdown_timer #(.TICK_DIV(T), .NUM_DIGITS(2), .START_SECS(0), .BONUS_SECS(B), .WARN_SECS(W)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(z_start), .pause(1'b0), .load(1'b0), .bonus(1'b0),
        .secs_left(z_secs), .time_ascii(z_ascii), .running(z_running), .paused(z_paused),
        .timer_done(z_done), .done_pulse(z_pulse), .warn(z_warn));

    int vectors = 0;
    int miscompares = 0;

    // Reference model: seconds remaining, cycles elapsed in the current second, mode flags.
    int m_secs, m_frac;
    bit m_run, m_hold, m_over, m_pulse;

    function automatic logic [13:0] ascii_of(input int n);
        return {7'(32'h30 + (n / 10) % 10), 7'(32'h30 + n % 10)};
    endfunction

    task automatic model_reset();
        m_secs = S; m_frac = 0;
        m_run = 0; m_hold = 0; m_over = 0; m_pulse = 0;
    endtask

    task automatic model_step(input bit s, input bit p, input bit l, input bit b);
        bit tk;
        int n;
        m_pulse = 0;
        tk = 0;
        if (l) begin
            model_reset();
            return;
        end
        if (m_over) return;
        if (!m_run && !m_hold) begin
            if (s) begin
                m_frac = 0;
                if (S == 0) begin m_over = 1; m_pulse = 1; end
                else if (p) m_hold = 1;
                else m_run = 1;
            end
            return;
        end
        if (m_run) begin
            if (p) begin
                m_run = 0; m_hold = 1;
            end else begin
                m_frac++;
                if (m_frac == T) begin tk = 1; m_frac = 0; end
            end
        end else if (!p) begin
            m_hold = 0; m_run = 1;
        end
        n = m_secs + (b ? B : 0) - (tk ? 1 : 0);
        if (n < 0) n = 0;
        if (n > MAXS) n = MAXS;
        m_secs = n;
        if (tk && n == 0) begin
            m_run = 0; m_over = 1; m_pulse = 1;
        end
    endtask

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_model(input string tag);
        expect_eq({tag, ".secs"},  32'(secs_left),  32'(m_secs));
        expect_eq({tag, ".ascii"}, 32'(time_ascii), 32'(ascii_of(m_secs)));
        expect_eq({tag, ".run"},   32'(running),    32'(m_run));
        expect_eq({tag, ".pause"}, 32'(paused),     32'(m_hold));
        expect_eq({tag, ".done"},  32'(timer_done), 32'(m_over));
        expect_eq({tag, ".pulse"}, 32'(done_pulse), 32'(m_pulse));
        expect_eq({tag, ".warn"},  32'(warn),       32'((m_run || m_hold) && m_secs <= W));
    endtask

    task automatic apply(input bit s, input bit p, input bit l, input bit b, input string tag);
        start = s; pause = p; load = l; bonus = b;
        model_step(s, p, l, b);
        @(posedge clk);
        #1;
        check_model(tag);
        start = 1'b0; load = 1'b0; bonus = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses;
        int held;
        bit found;
        bit rp;

        // Asynchronous reset from power-up.
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_model("reset");
        expect_eq("reset_ascii", 32'(time_ascii), 32'({7'h30, 7'h33}));
        expect_eq("reset97_secs", 32'(a_secs), 32'd97);
        expect_eq("reset0_ascii", 32'(z_ascii), 32'({7'h30, 7'h30}));
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full countdown 3 -> 0 with a single done pulse.
        apply(1, 0, 0, 0, "start");
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            apply(0, 0, 0, 0, "count");
            if (done_pulse) pulses++;
        end
        expect_eq("done_pulse_once", 32'(pulses), 32'd1);
        expect_eq("done_held", 32'(timer_done), 32'd1);
        expect_eq("done_ascii", 32'(time_ascii), 32'({7'h30, 7'h30}));
        apply(1, 1, 0, 1, "done_sticky");
        apply(0, 0, 1, 0, "load_done");
        expect_eq("load_done_secs", 32'(secs_left), 32'd3);

        // Pause two cycles into a second; fraction must survive the hold.
        apply(1, 0, 0, 0, "start2");
        apply(0, 0, 0, 0, "frac1");
        apply(0, 0, 0, 0, "frac2");
        for (int i = 0; i < 10; i++) apply(0, 1, 0, 0, "hold");
        expect_eq("hold_secs", 32'(secs_left), 32'd3);
        apply(0, 0, 0, 0, "release");
        held = int'(secs_left);
        apply(0, 0, 0, 0, "rel_plus1");
        expect_eq("no_tick_rel1", 32'(secs_left), 32'(held));
        apply(0, 0, 0, 0, "rel_plus2");
        expect_eq("tick_rel2", 32'(secs_left), 32'(held - 1));

        // Bonus coinciding with the final tick.
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (m_run && m_secs == 1 && m_frac == T - 1) begin
                found = 1;
                break;
            end
            apply(0, 0, 0, 0, "to_last");
        end
        expect_eq("align_last_tick", 32'(found), 32'd1);
        apply(0, 0, 0, 1, "bonus_tick");
        expect_eq("bonus_tick_secs", 32'(secs_left), 32'd5);
        expect_eq("bonus_tick_pulse", 32'(done_pulse), 32'd0);
        expect_eq("bonus_tick_warn", 32'(warn), 32'd0);

        // Reload while running, then load and start together.
        apply(0, 0, 1, 0, "load_run");
        expect_eq("load_run_flag", 32'(running), 32'd0);
        apply(1, 0, 1, 0, "load_start");
        expect_eq("load_start_idle", 32'(running | paused), 32'd0);
        apply(0, 0, 0, 1, "idle_bonus");

        // Random traffic against the model.
        rp = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) rp = ~rp;
            apply($urandom_range(0, 7) == 0, rp, $urandom_range(0, 24) == 0,
                  $urandom_range(0, 9) == 0, "rand");
        end

        // Asynchronous reset mid-second while running.
        apply(0, 0, 1, 0, "pre_reset_load");
        apply(1, 0, 0, 0, "pre_reset_start");
        for (int i = 0; i < 6; i++) apply(0, 0, 0, 0, "pre_reset_run");
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_model("async_reset");
        expect_eq("async_reset_secs", 32'(secs_left), 32'd3);
        #2 rst_n = 1'b1;

        // START_SECS=97 build: repeated bonus saturates at 99.
        a_start = 1'b1;
        apply(0, 0, 0, 0, "idle97a");
        a_start = 1'b0;
        a_bonus = 1'b1;
        for (int i = 0; i < 3; i++) apply(0, 0, 0, 0, "idle97b");
        a_bonus = 1'b0;
        expect_eq("sat_secs", 32'(a_secs), 32'd99);
        expect_eq("sat_ascii", 32'(a_ascii), 32'({7'h39, 7'h39}));
        expect_eq("sat_running", 32'(a_running), 32'd1);

        // START_SECS=0 build: start goes straight to DONE.
        z_start = 1'b1;
        apply(0, 0, 0, 0, "idle0a");
        z_start = 1'b0;
        expect_eq("zero_done", 32'(z_done), 32'd1);
        expect_eq("zero_pulse", 32'(z_pulse), 32'd1);
        expect_eq("zero_secs", 32'(z_secs), 32'd0);
        apply(0, 0, 0, 0, "idle0b");
        expect_eq("zero_pulse_drop", 32'(z_pulse), 32'd0);
        expect_eq("zero_done_held", 32'(z_done), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
